// File: rtl/prime_seq_gen.sv
// prime_seq_gen: emits every prime in [2, 2^WIDTH-1] in ascending order over a valid/ready
// stream, then raises done. Primality is decided by trial division; the remainder is formed by
// repeated subtraction, so per-candidate latency depends on the data.
//
// Parameters:
//   WIDTH  bit width of candidate, divisor and prime output (>= 2)
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  begin a new sequence; honoured only when idle or done
//   ready  downstream accepts prime when valid && ready
//   valid  prime holds a prime not yet accepted
//   prime  current prime, stable while valid && !ready
//   busy   high from start acceptance until entry to the done state
//   done   level, high once the whole range has been emitted
//   count  (only with PRIME_SEQ_COUNT_EN) number of transfers since the last accepted start
//
// Build option: define PRIME_SEQ_COUNT_EN to add the count output.
module prime_seq_gen #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] prime,
  output logic             busy,
  output logic             done
`ifdef PRIME_SEQ_COUNT_EN
  ,
  output logic [WIDTH-1:0] count
`endif
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StTest,
    StDiv,
    StEmit,
    StNext,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] prime_q, prime_d;

  logic [2*WIDTH-1:0] div_ext, cand_ext, div_sq;
  logic               cand_last;
  logic               start_ok;
  logic               xfer;

  // Square at double width so div*div can never wrap for any legal divisor.
  assign div_ext   = {{WIDTH{1'b0}}, div_q};
  assign cand_ext  = {{WIDTH{1'b0}}, cand_q};
  assign div_sq    = div_ext * div_ext;
  assign cand_last = (cand_q == {WIDTH{1'b1}});
  assign start_ok  = start && ((state_q == StIdle) || (state_q == StDone));
  assign xfer      = (state_q == StEmit) && ready;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    div_d   = div_q;
    rem_d   = rem_q;
    prime_d = prime_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          cand_d  = WIDTH'(2);
          state_d = StInit;
        end
      end
      StInit: begin
        div_d   = WIDTH'(2);
        rem_d   = cand_q;
        state_d = StTest;
      end
      StTest: begin
        // No divisor up to sqrt(cand) divided it: cand is prime.
        if (div_sq > cand_ext) begin
          prime_d = cand_q;
          state_d = StEmit;
        end else begin
          state_d = StDiv;
        end
      end
      StDiv: begin
        if (rem_q >= div_q) begin
          rem_d = rem_q - div_q;
        end else if (rem_q == '0) begin
          state_d = StNext;
        end else begin
          div_d   = div_q + 1'b1;
          rem_d   = cand_q;
          state_d = StTest;
        end
      end
      StEmit: begin
        if (xfer) begin
          state_d = StNext;
        end
      end
      StNext: begin
        // Stop at the top of the range rather than wrapping back to 0.
        if (cand_last) begin
          state_d = StDone;
        end else begin
          cand_d  = cand_q + 1'b1;
          state_d = StInit;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cand_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      prime_q <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      div_q   <= div_d;
      rem_q   <= rem_d;
      prime_q <= prime_d;
    end
  end

  assign valid = (state_q == StEmit);
  assign prime = prime_q;
  assign busy  = (state_q != StIdle) && (state_q != StDone);
  assign done  = (state_q == StDone);

`ifdef PRIME_SEQ_COUNT_EN
  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (start_ok) begin
      count_q <= '0;
    end else if (xfer) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
`else
  // Without the counter, start_ok has no consumer beyond documenting start acceptance.
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_prime_seq_gen.sv
module tb_prime_seq_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start8, ready8, valid8, busy8, done8;
  logic [7:0] prime8;
  logic       start3, ready3, valid3, busy3, done3;
  logic [2:0] prime3;
`ifdef PRIME_SEQ_COUNT_EN
  logic [7:0] count8;
  logic [2:0] count3;
`endif

  prime_seq_gen #(.WIDTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .start (start8),
    .ready (ready8),
    .valid (valid8),
    .prime (prime8),
    .busy  (busy8),
    .done  (done8)
`ifdef PRIME_SEQ_COUNT_EN
    ,
    .count (count8)
`endif
  );

  prime_seq_gen #(.WIDTH(3)) u_dut3 (
    .clk   (clk),
    .rst   (rst),
    .start (start3),
    .ready (ready3),
    .valid (valid3),
    .prime (prime3),
    .busy  (busy3),
    .done  (done3)
`ifdef PRIME_SEQ_COUNT_EN
    ,
    .count (count3)
`endif
  );

  int checks = 0;
  int errors = 0;

  int exp8_q[$];
  int exp3_q[$];
  int seen3[$];
  int xfer8 = 0, last8 = 0, xfer3 = 0, last3 = 0;
  bit hold8 = 0, hold3 = 0;
  int hold_p8 = 0, hold_p3 = 0;

  typedef struct {
    int duty;
    bit poke;
    int exp_n;
    int exp_last;
  } vec_t;
  vec_t vecs[3];
  int   golden3[4];

  function automatic bit model_is_prime(input int v);
    if (v < 2) return 1'b0;
    for (int d = 2; d * d <= v; d++) begin
      if (v % d == 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Scoreboard side: expected primes come from an independent trial-division model.
  task automatic push_model8;
    for (int v = 2; v < 256; v++) if (model_is_prime(v)) exp8_q.push_back(v);
  endtask

  task automatic push_model3;
    for (int v = 2; v < 8; v++) if (model_is_prime(v)) exp3_q.push_back(v);
  endtask

  // Monitors sample at the falling edge: valid && ready here means a transfer at the next rise.
  always @(negedge clk) begin
    int e;
    if (rst) begin
      hold8 = 1'b0;
    end else begin
      if (hold8) begin
        check("hold_valid8", valid8, 1);
        check("hold_prime8", prime8, hold_p8);
      end
      if (valid8 && ready8) begin
        if (exp8_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra8: got %0d expected no transfer", prime8);
        end else begin
          e = exp8_q.pop_front();
          check("order8", prime8, e);
        end
        xfer8++;
        last8 = int'(prime8);
      end
      hold8   = valid8 && !ready8;
      hold_p8 = int'(prime8);
    end
  end

  always @(negedge clk) begin
    int e;
    if (rst) begin
      hold3 = 1'b0;
    end else begin
      if (hold3) begin
        check("hold_valid3", valid3, 1);
        check("hold_prime3", prime3, hold_p3);
      end
      if (valid3 && ready3) begin
        if (exp3_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra3: got %0d expected no transfer", prime3);
        end else begin
          e = exp3_q.pop_front();
          check("order3", prime3, e);
        end
        xfer3++;
        last3 = int'(prime3);
        seen3.push_back(int'(prime3));
      end
      hold3   = valid3 && !ready3;
      hold_p3 = int'(prime3);
    end
  end

  task automatic run3(input vec_t v);
    int n;
    push_model3();
    xfer3 = 0;
    seen3.delete();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    check("start_busy3", busy3, 1);
    check("start_done3", done3, 0);
`ifdef PRIME_SEQ_COUNT_EN
    check("start_count3", count3, 0);
`endif
    n = 0;
    while (!done3 && n < 2000) begin
      ready3 = ($urandom_range(99) < v.duty);
      start3 = v.poke && busy3 && ($urandom_range(3) == 0);
      tick();
      n++;
    end
    start3 = 1'b0;
    ready3 = 1'b0;
    check("end_done3", done3, 1);
    check("end_busy3", busy3, 0);
    check("end_valid3", valid3, 0);
    check("end_xfers3", xfer3, v.exp_n);
    check("end_last3", last3, v.exp_last);
    check("end_queue3", exp3_q.size(), 0);
`ifdef PRIME_SEQ_COUNT_EN
    check("end_count3", count3, v.exp_n);
`endif
    for (int i = 0; i < seen3.size() && i < 4; i++) begin
      check("golden3", seen3[i], golden3[i]);
      check("is_prime3", model_is_prime(seen3[i]), 1);
    end
  endtask

  initial begin
    int n;
    vecs[0]    = '{100, 1'b0, 4, 7};
    vecs[1]    = '{50, 1'b1, 4, 7};
    vecs[2]    = '{25, 1'b1, 4, 7};
    golden3[0] = 2;
    golden3[1] = 3;
    golden3[2] = 5;
    golden3[3] = 7;

    rst    = 1'b1;
    start8 = 1'b0;
    ready8 = 1'b0;
    start3 = 1'b0;
    ready3 = 1'b0;
    repeat (3) tick();
    check("rst_valid8", valid8, 0);
    check("rst_prime8", prime8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_valid3", valid3, 0);
    check("rst_busy3", busy3, 0);
`ifdef PRIME_SEQ_COUNT_EN
    check("rst_count8", count8, 0);
`endif
    rst = 1'b0;
    tick();
    check("idle_busy8", busy8, 0);

    // Latency, backpressure on 3, then reset right after 5 is taken.
    push_model8();
    xfer8  = 0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("lat_busy", busy8, 1);
    check("lat_valid_init", valid8, 0);
    tick();
    check("lat_valid_test", valid8, 0);
    tick();
    check("lat_first_valid", valid8, 1);
    check("lat_first_prime", prime8, 2);
    ready8 = 1'b1;
    tick();
    ready8 = 1'b0;
    n = 0;
    while (!valid8 && n < 200) begin
      tick();
      n++;
    end
    check("bp_valid", valid8, 1);
    check("bp_prime", prime8, 3);
    repeat (5) begin
      tick();
      check("bp_hold_valid", valid8, 1);
      check("bp_hold_prime", prime8, 3);
    end
    ready8 = 1'b1;
    n = 0;
    while (last8 != 5 && n < 500) begin
      tick();
      n++;
    end
    check("bp_last", last8, 5);
    check("bp_xfers", xfer8, 3);
    ready8 = 1'b0;
    rst    = 1'b1;
    tick();
    check("abort_valid", valid8, 0);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_prime", prime8, 0);
    rst = 1'b0;
    exp8_q.delete();
    tick();
    check("abort_idle_busy", busy8, 0);
    check("abort_idle_valid", valid8, 0);

    // Full 8-bit run after the abort: restarts at 2, ignores start while busy.
    push_model8();
    xfer8  = 0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    check("full_busy", busy8, 1);
    n = 0;
    while (!done8 && n < 60000) begin
      ready8 = ($urandom_range(99) < 70);
      start8 = busy8 && ($urandom_range(15) == 0);
      tick();
      n++;
    end
    start8 = 1'b0;
    ready8 = 1'b0;
    check("full_done", done8, 1);
    check("full_busy_end", busy8, 0);
    check("full_valid_end", valid8, 0);
    check("full_xfers", xfer8, 54);
    check("full_last", last8, 251);
    check("full_queue", exp8_q.size(), 0);
`ifdef PRIME_SEQ_COUNT_EN
    check("full_count", count8, 54);
`endif

    // 3-bit runs; rows after the first restart from the done state.
    for (int i = 0; i < 3; i++) run3(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
